// File: rtl/box_overlay_stream.sv
// Streaming rectangle overlay between two FWFT FIFOs: one register stage,
// internal raster tracking and per-frame sampling of the box configuration.
module box_overlay_stream #(
  parameter int DATA_WIDTH  = 24,
  parameter int COORD_WIDTH = 10,
  parameter int IMG_WIDTH   = 720,
  parameter int IMG_HEIGHT  = 540,
  parameter int NUM_BOXES   = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_BOXES*COORD_WIDTH-1:0]   box_x,
  input  logic [NUM_BOXES*COORD_WIDTH-1:0]   box_y,
  input  logic [NUM_BOXES*COORD_WIDTH-1:0]   box_w,
  input  logic [NUM_BOXES*COORD_WIDTH-1:0]   box_h,
  input  logic [NUM_BOXES-1:0]               box_en,
  input  logic [NUM_BOXES-1:0]               box_fill,
  input  logic [3:0]                         thickness,
  input  logic [DATA_WIDTH-1:0]              box_color,
  input  logic                               in_empty,
  output logic                               in_rd_en,
  input  logic [DATA_WIDTH-1:0]              in_din,
  input  logic                               out_full,
  output logic                               out_wr_en,
  output logic [DATA_WIDTH-1:0]              out_dout,
  output logic                               frame_done
);

  localparam int AW = COORD_WIDTH + 1;
  localparam int BW = NUM_BOXES * COORD_WIDTH;
  localparam logic [COORD_WIDTH-1:0] LAST_COL = COORD_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_ROW = COORD_WIDTH'(IMG_HEIGHT - 1);

  logic                   valid;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [COORD_WIDTH-1:0] col;
  logic [COORD_WIDTH-1:0] row;
  logic                   at_origin;
  logic                   last_col;
  logic                   last_row;

  logic [BW-1:0]          sh_x;
  logic [BW-1:0]          sh_y;
  logic [BW-1:0]          sh_w;
  logic [BW-1:0]          sh_h;
  logic [NUM_BOXES-1:0]   sh_en;
  logic [NUM_BOXES-1:0]   sh_fill;
  logic [3:0]             sh_thick;
  logic [DATA_WIDTH-1:0]  sh_color;

  logic [BW-1:0]          eff_x;
  logic [BW-1:0]          eff_y;
  logic [BW-1:0]          eff_w;
  logic [BW-1:0]          eff_h;
  logic [NUM_BOXES-1:0]   eff_en;
  logic [NUM_BOXES-1:0]   eff_fill;
  logic [3:0]             eff_thick;
  logic [DATA_WIDTH-1:0]  eff_color;

  logic [AW-1:0]          t_ext;
  logic [AW-1:0]          col_e;
  logic [AW-1:0]          row_e;
  logic [NUM_BOXES-1:0]   hit;
  logic [DATA_WIDTH-1:0]  pix_next;

  assign out_wr_en = valid && !out_full;
  assign in_rd_en  = !in_empty && (!valid || !out_full);
  assign out_dout  = data_q;

  assign at_origin = (col == '0) && (row == '0);
  assign last_col  = (col == LAST_COL);
  assign last_row  = (row == LAST_ROW);

  // First pixel of a frame sees the live config; the rest of the frame sees
  // the copy captured when that pixel was accepted.
  assign eff_x     = at_origin ? box_x     : sh_x;
  assign eff_y     = at_origin ? box_y     : sh_y;
  assign eff_w     = at_origin ? box_w     : sh_w;
  assign eff_h     = at_origin ? box_h     : sh_h;
  assign eff_en    = at_origin ? box_en    : sh_en;
  assign eff_fill  = at_origin ? box_fill  : sh_fill;
  assign eff_thick = at_origin ? thickness : sh_thick;
  assign eff_color = at_origin ? box_color : sh_color;

  assign t_ext = (eff_thick == 4'd0) ? AW'(1) : AW'(eff_thick);
  assign col_e = {1'b0, col};
  assign row_e = {1'b0, row};

  for (genvar i = 0; i < NUM_BOXES; i++) begin : g_slot
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [AW-1:0] w;
    logic [AW-1:0] h;
    logic [AW-1:0] x_end;
    logic [AW-1:0] y_end;
    logic [AW-1:0] x_in;
    logic [AW-1:0] y_in;
    logic          in_box;
    logic          on_edge;

    assign x     = {1'b0, eff_x[i*COORD_WIDTH +: COORD_WIDTH]};
    assign y     = {1'b0, eff_y[i*COORD_WIDTH +: COORD_WIDTH]};
    assign w     = {1'b0, eff_w[i*COORD_WIDTH +: COORD_WIDTH]};
    assign h     = {1'b0, eff_h[i*COORD_WIDTH +: COORD_WIDTH]};
    assign x_end = x + w;
    assign y_end = y + h;
    // Saturating inner bound: a thickness of half the size or more paints solid.
    assign x_in  = (x_end > t_ext) ? (x_end - t_ext) : '0;
    assign y_in  = (y_end > t_ext) ? (y_end - t_ext) : '0;

    assign in_box  = eff_en[i] && (w != '0) && (h != '0) &&
                     (col_e >= x) && (col_e < x_end) &&
                     (row_e >= y) && (row_e < y_end);
    assign on_edge = (col_e < x + t_ext) || (col_e >= x_in) ||
                     (row_e < y + t_ext) || (row_e >= y_in);
    assign hit[i]  = in_box && (eff_fill[i] || on_edge);
  end

  assign pix_next = (|hit) ? eff_color : in_din;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      data_q <= '0;
    end else if (in_rd_en) begin
      valid  <= 1'b1;
      data_q <= pix_next;
    end else if (out_wr_en) begin
      valid  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (in_rd_en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_rd_en && last_col && last_row;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_w     <= '0;
      sh_h     <= '0;
      sh_en    <= '0;
      sh_fill  <= '0;
      sh_thick <= '0;
      sh_color <= '0;
    end else if (in_rd_en && at_origin) begin
      sh_x     <= box_x;
      sh_y     <= box_y;
      sh_w     <= box_w;
      sh_h     <= box_h;
      sh_en    <= box_en;
      sh_fill  <= box_fill;
      sh_thick <= thickness;
      sh_color <= box_color;
    end
  end

endmodule
